// File: rtl/uart_rx_if.sv
// Byte-side bundle of the serial receiver: raw rx line in, framed byte and strobes out.
interface uart_rx_if;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   modport master (input rx, output data, valid, frame_err, parity_err, busy);
   modport slave  (output rx, input data, valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with one-cycle valid/frame_err strobes and a break-hold state.
// Optional even parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_rx_if.master bus
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    shreg, sh_n;
   logic [7:0]    data_r;
   logic          rx_meta, rx_s;
   logic          load, valid_n, ferr_n;
   logic          valid_r, ferr_r, busy_r;
`ifdef UART_RX_PARITY_EN
   logic          par_bad, par_bad_n;
   logic          perr_n, perr_r;
`endif

   // rx is asynchronous to clk; only rx_s may be used past this point
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + CNT_ONE;
      idx_n   = idx;
      sh_n    = shreg;
      load    = 1'b0;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_n = par_bad;
      perr_n    = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            if (cnt == CNT_HALF) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_n = '0;
               sh_n  = {rx_s, shreg[7:1]};
               idx_n = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (idx == 3'd7) state_n = PARITY;
`else
               if (idx == 3'd7) state_n = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == CNT_LAST) begin
               cnt_n     = '0;
               par_bad_n = ^shreg ^ rx_s;
               state_n   = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_n = '0;
               if (rx_s) begin
                  load    = 1'b1;
                  valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                  perr_n  = par_bad;
`endif
                  state_n = IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = BRK;
               end
            end
         end
         // a held-low line parks here so it yields one frame_err, not a stream of frames
         BRK: begin
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         data_r  <= '0;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         busy_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad <= 1'b0;
         perr_r  <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         shreg   <= sh_n;
         if (load) data_r <= shreg;
         valid_r <= valid_n;
         ferr_r  <= ferr_n;
         busy_r  <= (state_n != IDLE);
`ifdef UART_RX_PARITY_EN
         par_bad <= par_bad_n;
         perr_r  <= perr_n;
`endif
      end
   end

   assign bus.data      = data_r;
   assign bus.valid     = valid_r;
   assign bus.frame_err = ferr_r;
   assign bus.busy      = busy_r;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = perr_r;
`else
   assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that turns the board's asynchronous RX line into byte-wide data with a one-cycle valid strobe. It sits directly upstream of the pulse/LED output stage in the read_serial design: received bytes drive the pulse stage's period and width selection. 8 data bits, LSB first, 1 stop bit, fixed baud set by parameter. No flow control and no buffering: each byte is presented once.

## Interface
- CLKS_PER_BIT, 104, clk cycles per serial bit (12 MHz / 115200); must be >= 4
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- rx  input  1  raw serial line; idles high; asynchronous to clk
- data  output  8  last correctly framed byte; holds until the next good byte
- valid  output  1  one-cycle strobe; data is new in that cycle
- frame_err  output  1  one-cycle strobe; stop bit sampled low
- parity_err  output  1  one-cycle strobe; parity mismatch (tied 0 unless UART_RX_PARITY_EN)
- busy  output  1  high whenever FSM is not IDLE

## Operation
- rx passes through a 2-flop synchronizer (both flops reset to 1); the FSM sees only the second flop, rx_s.
- Terms: HALF = CLKS_PER_BIT/2 (integer division). Bit counter cnt is $clog2(CLKS_PER_BIT) bits wide and never wraps past CLKS_PER_BIT-1. Bit index is 3 bits.
- IDLE: if rx_s==0, go to START with cnt=0.
- START: when cnt==HALF-1, resample rx_s. If 0, go to DATA with cnt=0 and index=0. If 1, treat as a glitch and return to IDLE with no strobe.
- DATA: when cnt==CLKS_PER_BIT-1, shift rx_s into a shift register (LSB first) and set cnt=0. After index 7, go to STOP (or PARITY if enabled).
- STOP: when cnt==CLKS_PER_BIT-1, sample rx_s.
  - If 1: load data from the shift register, pulse valid, go to IDLE.
  - If 0: pulse frame_err, leave data unchanged, go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. A held-low line therefore produces exactly one frame_err, not repeated frames.
- Strobe exclusivity: valid and frame_err never assert together. With parity enabled, parity_err may coincide with valid (data is still loaded).
- Reset mid-byte: FSM goes to IDLE immediately; the partial byte is discarded; no strobe is generated.

## Timing
- Reset values: data=8'h00, valid=0, frame_err=0, parity_err=0, busy=0, FSM=IDLE, cnt=0.
- Reference edge: E0 is the first clk edge that samples rx low.
  - E2: FSM enters START.
  - E(2+HALF): enters DATA.
  - Bit k is sampled at E(2+HALF+(k+1)*CLKS_PER_BIT).
  - Stop bit is sampled at E(2+HALF+9*CLKS_PER_BIT). valid/data update on that edge.
  - For the default parameter, that is E990.
- Back-to-back frames: IDLE is re-entered half a bit before the stop bit ends, so a start bit immediately following the stop bit is caught with no required idle gap.
- All outputs are registered; there is no combinational path from rx to any output.
- Strobes are exactly one cycle wide.

## Configuration
- UART_RX_PARITY_EN defined: a PARITY state follows DATA and samples an even-parity bit after CLKS_PER_BIT cycles. parity_err pulses when (^shift_reg ^ bit) != 0. The stop bit and all subsequent timing shift by CLKS_PER_BIT.
- Not defined: no PARITY state; frame = start + 8 data + stop; parity_err is constant 0.

## Test plan
- Send 0xA5 (CLKS_PER_BIT=104) -> valid pulses for one cycle after E990; data=8'hA5; frame_err=0; busy falls at the same edge.
- Pulse rx low for 20 cycles, then high -> FSM returns to IDLE at E54; no valid or frame_err; data unchanged.
- Send 0x3C with stop bit forced 0, hold rx low for 500 more cycles, then release and send 0x42 -> exactly one frame_err; data stays at the prior value until 0x42 gives valid with data=8'h42.
- Send 0x00 then 0xFF with no gap after the stop bit -> two valid strobes 10*104 cycles apart; data=8'h00, then 8'hFF.
- Assert rst_n low in the middle of bit 4 of 0x81, release, then send 0x7E -> all outputs zero during reset; no strobe for the partial byte; next valid carries 8'h7E.
- With UART_RX_PARITY_EN defined, send 0x03 with parity bit 1, then 0x03 with parity bit 0 -> first frame: valid and parity_err together; second frame: valid only; both with data=8'h03.
